// File: rtl/rvfi_reorder_buffer.sv
// Reorders up to NRET out-of-order RVFI retirements per cycle by rvfi_order and
// re-emits them one per cycle in strict program order, flagging window/duplicate errors.
module rvfi_reorder_buffer #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NRET  = 2,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NRET-1:0]          in_valid,
  input  logic [NRET*8-1:0]        in_order,
  input  logic [NRET*32-1:0]       in_insn,
  input  logic [NRET-1:0]          in_trap,
  input  logic [NRET*XLEN-1:0]     in_mem_addr,
  input  logic [NRET*XLEN/8-1:0]   in_mem_rmask,
  input  logic [NRET*XLEN/8-1:0]   in_mem_wmask,
  input  logic [NRET*XLEN-1:0]     in_mem_rdata,
  input  logic [NRET*XLEN-1:0]     in_mem_wdata,
  output logic                     out_valid,
  output logic [7:0]               out_order,
  output logic [31:0]              out_insn,
  output logic                     out_trap,
  output logic [XLEN-1:0]          out_mem_addr,
  output logic [XLEN/8-1:0]        out_mem_rmask,
  output logic [XLEN/8-1:0]        out_mem_wmask,
  output logic [XLEN-1:0]          out_mem_rdata,
  output logic [XLEN-1:0]          out_mem_wdata,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     err,
  output logic [1:0]               err_cause
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned OW = AW + 1;
  localparam int unsigned MW = XLEN / 8;

  localparam logic [1:0] CAUSE_NONE   = 2'd0;
  localparam logic [1:0] CAUSE_WINDOW = 2'd1;
  localparam logic [1:0] CAUSE_COLL   = 2'd2;
  localparam logic [1:0] CAUSE_DUP    = 2'd3;

  logic [7:0]       expected_q, expected_d;
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [OW-1:0]    occ_q, occ_d;
  logic             err_q, err_d;
  logic [1:0]       cause_q, cause_d;

  logic             out_valid_q, out_valid_d;
  logic [7:0]       out_order_q, out_order_d;
  logic [31:0]      out_insn_q, out_insn_d;
  logic             out_trap_q, out_trap_d;
  logic [XLEN-1:0]  out_addr_q, out_addr_d;
  logic [MW-1:0]    out_rmask_q, out_rmask_d;
  logic [MW-1:0]    out_wmask_q, out_wmask_d;
  logic [XLEN-1:0]  out_rdata_q, out_rdata_d;
  logic [XLEN-1:0]  out_wdata_q, out_wdata_d;

  logic [7:0]       slot_order_q [DEPTH];
  logic [7:0]       slot_order_d [DEPTH];
  logic [31:0]      slot_insn_q  [DEPTH];
  logic [31:0]      slot_insn_d  [DEPTH];
  logic             slot_trap_q  [DEPTH];
  logic             slot_trap_d  [DEPTH];
  logic [XLEN-1:0]  slot_addr_q  [DEPTH];
  logic [XLEN-1:0]  slot_addr_d  [DEPTH];
  logic [MW-1:0]    slot_rmask_q [DEPTH];
  logic [MW-1:0]    slot_rmask_d [DEPTH];
  logic [MW-1:0]    slot_wmask_q [DEPTH];
  logic [MW-1:0]    slot_wmask_d [DEPTH];
  logic [XLEN-1:0]  slot_rdata_q [DEPTH];
  logic [XLEN-1:0]  slot_rdata_d [DEPTH];
  logic [XLEN-1:0]  slot_wdata_q [DEPTH];
  logic [XLEN-1:0]  slot_wdata_d [DEPTH];

  logic [AW-1:0]    exp_idx;
  logic             drain;
  logic [NRET-1:0]  in_win;
  logic [OW-1:0]    wr_cnt;
  logic [1:0]       first_cause;

  always_comb begin
    expected_d   = expected_q;
    valid_d      = valid_q;
    err_d        = err_q;
    cause_d      = cause_q;
    out_valid_d  = 1'b0;
    out_order_d  = out_order_q;
    out_insn_d   = out_insn_q;
    out_trap_d   = out_trap_q;
    out_addr_d   = out_addr_q;
    out_rmask_d  = out_rmask_q;
    out_wmask_d  = out_wmask_q;
    out_rdata_d  = out_rdata_q;
    out_wdata_d  = out_wdata_q;
    slot_order_d = slot_order_q;
    slot_insn_d  = slot_insn_q;
    slot_trap_d  = slot_trap_q;
    slot_addr_d  = slot_addr_q;
    slot_rmask_d = slot_rmask_q;
    slot_wmask_d = slot_wmask_q;
    slot_rdata_d = slot_rdata_q;
    slot_wdata_d = slot_wdata_q;
    wr_cnt       = '0;
    first_cause  = CAUSE_NONE;
    in_win       = '0;

    exp_idx = expected_q[AW-1:0];
    drain   = valid_q[exp_idx];

    // Drain clears the slot before writes are applied, so a write to the
    // drained slot (only reachable with order == expected) takes effect.
    if (drain) begin
      out_valid_d  = 1'b1;
      out_order_d  = slot_order_q[exp_idx];
      out_insn_d   = slot_insn_q[exp_idx];
      out_trap_d   = slot_trap_q[exp_idx];
      out_addr_d   = slot_addr_q[exp_idx];
      out_rmask_d  = slot_rmask_q[exp_idx];
      out_wmask_d  = slot_wmask_q[exp_idx];
      out_rdata_d  = slot_rdata_q[exp_idx];
      out_wdata_d  = slot_wdata_q[exp_idx];
      valid_d[exp_idx] = 1'b0;
      expected_d   = expected_q + 8'd1;
    end

    for (int unsigned c = 0; c < NRET; c++) begin
      in_win[c] = 8'(in_order[c*8 +: 8] - expected_q) < 8'(DEPTH);
    end

    for (int unsigned c = 0; c < NRET; c++) begin
      logic [AW-1:0] idx;
      logic          dup;
      logic [1:0]    cause_c;
      idx     = in_order[c*8 +: AW];
      dup     = 1'b0;
      cause_c = CAUSE_NONE;
      for (int unsigned k = 0; k < c; k++) begin
        if (in_valid[k] && in_win[k] && (in_order[k*8 +: AW] == idx)) dup = 1'b1;
      end
      if (in_valid[c]) begin
        if (!in_win[c]) begin
          cause_c = CAUSE_WINDOW;
        end else if (dup) begin
          cause_c = CAUSE_DUP;
        end else if (valid_q[idx] && !(drain && (idx == exp_idx))) begin
          cause_c = CAUSE_COLL;
        end else begin
          valid_d[idx]      = 1'b1;
          slot_order_d[idx] = in_order[c*8 +: 8];
          slot_insn_d[idx]  = in_insn[c*32 +: 32];
          slot_trap_d[idx]  = in_trap[c];
          slot_addr_d[idx]  = in_mem_addr[c*XLEN +: XLEN];
          slot_rmask_d[idx] = in_mem_rmask[c*MW +: MW];
          slot_wmask_d[idx] = in_mem_wmask[c*MW +: MW];
          slot_rdata_d[idx] = in_mem_rdata[c*XLEN +: XLEN];
          slot_wdata_d[idx] = in_mem_wdata[c*XLEN +: XLEN];
          wr_cnt            = wr_cnt + OW'(1);
        end
      end
      if ((first_cause == CAUSE_NONE) && (cause_c != CAUSE_NONE)) first_cause = cause_c;
    end

    occ_d = occ_q + wr_cnt - OW'(drain);

    if (!err_q && (first_cause != CAUSE_NONE)) begin
      err_d   = 1'b1;
      cause_d = first_cause;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      expected_q  <= '0;
      valid_q     <= '0;
      occ_q       <= '0;
      err_q       <= 1'b0;
      cause_q     <= CAUSE_NONE;
      out_valid_q <= 1'b0;
      out_order_q <= '0;
      out_insn_q  <= '0;
      out_trap_q  <= 1'b0;
      out_addr_q  <= '0;
      out_rmask_q <= '0;
      out_wmask_q <= '0;
      out_rdata_q <= '0;
      out_wdata_q <= '0;
    end else begin
      expected_q  <= expected_d;
      valid_q     <= valid_d;
      occ_q       <= occ_d;
      err_q       <= err_d;
      cause_q     <= cause_d;
      out_valid_q <= out_valid_d;
      out_order_q <= out_order_d;
      out_insn_q  <= out_insn_d;
      out_trap_q  <= out_trap_d;
      out_addr_q  <= out_addr_d;
      out_rmask_q <= out_rmask_d;
      out_wmask_q <= out_wmask_d;
      out_rdata_q <= out_rdata_d;
      out_wdata_q <= out_wdata_d;
    end
  end

  // Slot payloads are only observable through their valid bits, so no reset.
  always_ff @(posedge clk) begin
    slot_order_q <= slot_order_d;
    slot_insn_q  <= slot_insn_d;
    slot_trap_q  <= slot_trap_d;
    slot_addr_q  <= slot_addr_d;
    slot_rmask_q <= slot_rmask_d;
    slot_wmask_q <= slot_wmask_d;
    slot_rdata_q <= slot_rdata_d;
    slot_wdata_q <= slot_wdata_d;
  end

  assign out_valid     = out_valid_q;
  assign out_order     = out_order_q;
  assign out_insn      = out_insn_q;
  assign out_trap      = out_trap_q;
  assign out_mem_addr  = out_addr_q;
  assign out_mem_rmask = out_rmask_q;
  assign out_mem_wmask = out_wmask_q;
  assign out_mem_rdata = out_rdata_q;
  assign out_mem_wdata = out_wdata_q;
  assign occupancy     = occ_q;
  assign err           = err_q;
  assign err_cause     = cause_q;

endmodule
